// File: rtl/lut_scan_ctrl.sv
// ============================================================================
// Module   : lut_scan_ctrl
// Purpose  : Walks len addresses of mainLUT from base and streams the bytes
//            out through a credit-controlled FIFO with a running checksum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut_scan_ctrl #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] lut_a,
  input  logic [DW-1:0] lut_q,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] checksum
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [AW:0]   len_r;
  logic [AW:0]   issued;
  logic          s1;        // address on lut_a is a live read (ROM stage)
  logic          s2;        // lut_q holds a live read (capture stage)
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic pop;
  logic credit_ok;
  logic issue;
  logic drained;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign m_valid   = (count != '0);
  assign m_data    = mem[rd_ptr];
  assign pop       = m_valid & m_ready;
  // Credits count both queued beats and reads still in the ROM pipeline.
  assign credit_ok = (32'(count) + 32'(s1) + 32'(s2)) < 32'(FIFO_DEPTH);
  assign issue     = (state == RUN) && (issued < len_r) && credit_ok;
  assign drained   = !s1 && !s2 &&
                     ((count == '0) || ((count == CW'(1)) && pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_r    <= '0;
      issued   <= '0;
      lut_a    <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      checksum <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      s1 <= 1'b0;
      s2 <= s1;
      if (s2) begin
        mem[wr_ptr] <= lut_q;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        checksum <= checksum + m_data;
      end
      count <= count + CW'(s2) - CW'(pop);

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            checksum <= '0;
            busy     <= 1'b1;
            if (len != '0) begin
              len_r  <= len;
              lut_a  <= base;
              s1     <= 1'b1;
              issued <= (AW+1)'(1);
              state  <= RUN;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (issued == len_r) begin
            state <= DRAIN;
          end else if (issue) begin
            s1     <= 1'b1;
            lut_a  <= lut_a + AW'(1);
            issued <= issued + (AW+1)'(1);
          end
        end
        DRAIN: begin
          if (drained) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          // Entered with done already set after a scan; a zero-length
          // command arrives here with done low and pulses it one cycle later.
          if (done) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lut_scan_ctrl.sv
// ============================================================================
// Module   : tb_lut_scan_ctrl
// Purpose  : Directed self-checking bench for lut_scan_ctrl with a 1-cycle
//            registered ROM model (q = a ^ 8'h5A).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lut_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base = 8'h00;
  logic [8:0] len = 9'd0;
  logic       busy;
  logic       done;
  logic [7:0] lut_a;
  logic [7:0] lut_q = 8'h00;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] checksum;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int k;

  logic [7:0] beat_data[$];
  int         beat_cyc[$];
  int         done_cyc[$];

  lut_scan_ctrl #(.AW(8), .DW(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .lut_a(lut_a), .lut_q(lut_q),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    lut_q <= lut_a ^ 8'h5A;
  end

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      beat_data.push_back(m_data);
      beat_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
  end

  task automatic clear_logs();
    beat_data.delete();
    beat_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] l);
    @(posedge clk); #1;
    start = 1'b1; base = b; len = l;
    @(posedge clk); #1;
    k = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc && !ok; c++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_assert++; if (lut_a !== 8'h00) begin n_fail++; $display("FAIL reset_lut_a got %h want 00", lut_a); end
    n_assert++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    n_assert++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data got %h want 00", m_data); end
    n_assert++; if (checksum !== 8'h00) begin n_fail++; $display("FAIL reset_checksum got %h want 00", checksum); end
    #8 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] exp [4] = '{8'hAA, 8'hAB, 8'hA8, 8'hA9};
    bit ok;
    m_ready = 1'b1;
    clear_logs();
    do_start(8'hF0, 9'd4);
    n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise got %b want 1", busy); end
    n_assert++; if (lut_a !== 8'hF0) begin n_fail++; $display("FAIL basic_lut_a got %h want F0", lut_a); end
    wait_done(50, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL basic_done_timeout got 0 want 1"); end
    n_assert++; if (beat_data.size() != 4) begin n_fail++; $display("FAIL basic_beats got %0d want 4", beat_data.size()); end
    for (int i = 0; i < 4 && i < beat_data.size(); i++) begin
      n_assert++; if (beat_data[i] !== exp[i]) begin n_fail++; $display("FAIL basic_data[%0d] got %h want %h", i, beat_data[i], exp[i]); end
      n_assert++; if (beat_cyc[i] != k + 2 + i) begin n_fail++; $display("FAIL basic_beat_time[%0d] got %0d want %0d", i, beat_cyc[i], k + 2 + i); end
    end
    n_assert++; if (checksum !== 8'hA6) begin n_fail++; $display("FAIL basic_checksum got %h want A6", checksum); end
    n_assert++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", done_cyc.size()); end
    if (done_cyc.size() > 0) begin
      n_assert++; if (done_cyc[0] != k + 6) begin n_fail++; $display("FAIL basic_done_time got %0d want %0d", done_cyc[0], k + 6); end
    end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall got %b want 0", busy); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [7:0] exp_d [4] = '{8'hA4, 8'hA5, 8'h5A, 8'h5B};
    bit ok;
    m_ready = 1'b1;
    clear_logs();
    do_start(8'hFE, 9'd4);
    for (int i = 0; i < 4; i++) begin
      n_assert++; if (lut_a !== exp_a[i]) begin n_fail++; $display("FAIL wrap_lut_a[%0d] got %h want %h", i, lut_a, exp_a[i]); end
      @(posedge clk); #1;
    end
    wait_done(50, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL wrap_done_timeout got 0 want 1"); end
    n_assert++; if (beat_data.size() != 4) begin n_fail++; $display("FAIL wrap_beats got %0d want 4", beat_data.size()); end
    for (int i = 0; i < 4 && i < beat_data.size(); i++) begin
      n_assert++; if (beat_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL wrap_data[%0d] got %h want %h", i, beat_data[i], exp_d[i]); end
    end
    n_assert++; if (checksum !== 8'hFE) begin n_fail++; $display("FAIL wrap_checksum got %h want FE", checksum); end
  endtask

  task automatic test_sweep();
    int max_occ = 0;
    int bad = 0;
    bit ok = 1'b0;
    clear_logs();
    m_ready = 1'b1;
    do_start(8'h00, 9'd256);
    for (int c = 0; c < 3000 && !ok; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (int'(dut.count) > max_occ) max_occ = int'(dut.count);
      if (done_cyc.size() != 0) ok = 1'b1;
    end
    m_ready = 1'b1;
    n_assert++; if (!ok) begin n_fail++; $display("FAIL sweep_done_timeout got 0 want 1"); end
    n_assert++; if (beat_data.size() != 256) begin n_fail++; $display("FAIL sweep_beats got %0d want 256", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 256; i++)
      if (beat_data[i] !== (8'(i) ^ 8'h5A)) bad++;
    n_assert++; if (bad != 0) begin n_fail++; $display("FAIL sweep_order got %0d bad beats want 0", bad); end
    n_assert++; if (max_occ > 4) begin n_fail++; $display("FAIL sweep_occupancy got %0d want <=4", max_occ); end
    n_assert++; if (checksum !== 8'h80) begin n_fail++; $display("FAIL sweep_checksum got %h want 80", checksum); end
  endtask

  task automatic test_zero_and_busy_start();
    logic [7:0] exp [8] = '{8'h7A, 8'h7B, 8'h78, 8'h79, 8'h7E, 8'h7F, 8'h7C, 8'h7D};
    bit ok;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    clear_logs();
    do_start(8'h33, 9'd0);
    n_assert++; if (checksum !== 8'h00) begin n_fail++; $display("FAIL zero_checksum got %h want 00", checksum); end
    wait_done(10, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL zero_done_timeout got 0 want 1"); end
    if (done_cyc.size() > 0) begin
      n_assert++; if (done_cyc[0] != k + 1) begin n_fail++; $display("FAIL zero_done_time got %0d want %0d", done_cyc[0], k + 1); end
    end
    n_assert++; if (beat_data.size() != 0) begin n_fail++; $display("FAIL zero_beats got %0d want 0", beat_data.size()); end

    clear_logs();
    do_start(8'h20, 9'd8);
    repeat (2) @(posedge clk); #1;
    start = 1'b1; base = 8'h70; len = 9'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(60, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL busystart_done_timeout got 0 want 1"); end
    n_assert++; if (beat_data.size() != 8) begin n_fail++; $display("FAIL busystart_beats got %0d want 8", beat_data.size()); end
    for (int i = 0; i < 8 && i < beat_data.size(); i++) begin
      n_assert++; if (beat_data[i] !== exp[i]) begin n_fail++; $display("FAIL busystart_data[%0d] got %h want %h", i, beat_data[i], exp[i]); end
    end
    n_assert++; if (checksum !== 8'hDC) begin n_fail++; $display("FAIL busystart_checksum got %h want DC", checksum); end
    repeat (4) @(posedge clk); #1;
    n_assert++; if (done_cyc.size() != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL busystart_restart got %0d dones busy %b want 1 dones busy 0", done_cyc.size(), busy); end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    logic [7:0] a_mid;
    logic [7:0] sum = 8'h00;
    int bad = 0;
    int bad_order = 0;
    int outstanding;
    bit ok;
    m_ready = 1'b1;
    clear_logs();
    do_start(8'h40, 9'd12);
    repeat (2) @(posedge clk); #1;
    m_ready = 1'b0;
    held = m_data;
    a_mid = lut_a;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (m_data !== held || m_valid !== 1'b1) bad++;
      if (i == 2) a_mid = lut_a;
    end
    n_assert++; if (bad != 0) begin n_fail++; $display("FAIL bp_data_stable got %0d unstable cycles want 0", bad); end
    n_assert++; if (lut_a !== a_mid) begin n_fail++; $display("FAIL bp_lut_a_stall got %h want %h", lut_a, a_mid); end
    outstanding = int'(lut_a - 8'h40) + 1 - beat_data.size();
    n_assert++; if (outstanding != 4) begin n_fail++; $display("FAIL bp_outstanding got %0d want 4", outstanding); end
    m_ready = 1'b1;
    wait_done(60, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL bp_done_timeout got 0 want 1"); end
    n_assert++; if (beat_data.size() != 12) begin n_fail++; $display("FAIL bp_beats got %0d want 12", beat_data.size()); end
    for (int i = 0; i < 12; i++) sum = sum + ((8'h40 + 8'(i)) ^ 8'h5A);
    for (int i = 0; i < beat_data.size() && i < 12; i++)
      if (beat_data[i] !== ((8'h40 + 8'(i)) ^ 8'h5A)) bad_order++;
    n_assert++; if (bad_order != 0) begin n_fail++; $display("FAIL bp_order got %0d bad beats want 0", bad_order); end
    n_assert++; if (checksum !== sum) begin n_fail++; $display("FAIL bp_checksum got %h want %h", checksum, sum); end
  endtask

  task automatic test_reset_mid_scan();
    bit ok;
    m_ready = 1'b1;
    clear_logs();
    do_start(8'h30, 9'd8);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_assert++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_done got %b%b want 00", busy, done); end
    n_assert++; if (lut_a !== 8'h00) begin n_fail++; $display("FAIL rstmid_lut_a got %h want 00", lut_a); end
    n_assert++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_stream got %b/%h want 0/00", m_valid, m_data); end
    n_assert++; if (checksum !== 8'h00) begin n_fail++; $display("FAIL rstmid_checksum got %h want 00", checksum); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_logs();
    repeat (6) @(posedge clk); #1;
    n_assert++; if (beat_data.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_resume got %0d beats busy %b want 0 beats busy 0", beat_data.size(), busy); end
    do_start(8'h10, 9'd2);
    wait_done(30, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL rstmid_done_timeout got 0 want 1"); end
    n_assert++; if (beat_data.size() != 2) begin n_fail++; $display("FAIL rstmid_beats got %0d want 2", beat_data.size()); end
    if (beat_data.size() == 2) begin
      n_assert++; if (beat_data[0] !== 8'h4A || beat_data[1] !== 8'h4B) begin n_fail++; $display("FAIL rstmid_data got %h %h want 4A 4B", beat_data[0], beat_data[1]); end
    end
    n_assert++; if (checksum !== 8'h95) begin n_fail++; $display("FAIL rstmid_checksum got %h want 95", checksum); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_sweep();
    test_zero_and_busy_start();
    test_backpressure();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
